// File: rtl/rf_writeback_unit.sv
// Register-file write port arbiter: port A (pipeline WB) always wins; port B is queued in a FIFO.
// Optional macro WB_FWD_EN enables forwarding of the registered, not yet captured RF write.
module rf_writeback_unit #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int FD         = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          AValid,
    input  logic [AW-1:0] AAddr,
    input  logic [DW-1:0] AData,
    input  logic          BValid,
    output logic          BReady,
    input  logic [AW-1:0] BAddr,
    input  logic [DW-1:0] BData,
    output logic          RFWE,
    output logic [AW-1:0] RFWA,
    output logic [DW-1:0] RFWD,
    output logic          StallReq,
    input  logic [AW-1:0] FwdRA1,
    input  logic [AW-1:0] FwdRA2,
    output logic          FwdHit1,
    output logic          FwdHit2,
    output logic [DW-1:0] FwdData1,
    output logic [DW-1:0] FwdData2
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    wb_req_t       fifo_mem [FD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic    a_issue;
    logic    issue_vld;
    wb_req_t issue_req;
    logic    stall_next;

    assign full    = (count == CW'(FD));
    assign empty   = (count == '0);
    assign BReady  = !full;
    assign a_issue = AValid && (AAddr != '0);

    // r0 writes from B complete the handshake but are dropped here.
    assign push = BValid && !full && (BAddr != '0);
    // Pop decision uses the pre-push count, so a fresh entry waits one cycle.
    assign pop  = !a_issue && !empty;

    always_comb begin
        issue_vld = 1'b0;
        issue_req = '0;
        if (a_issue) begin
            issue_vld      = 1'b1;
            issue_req.addr = AAddr;
            issue_req.data = AData;
        end else if (pop) begin
            issue_vld = 1'b1;
            issue_req = fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {BAddr, BData};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stall is raised one cycle ahead of saturation so the pipeline bubble lines up with it.
    assign stall_next = !pop && (starve_cnt >= SW'(STARVE_MAX - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            starve_cnt <= '0;
            StallReq   <= 1'b0;
        end else begin
            StallReq <= stall_next;
            if (pop || empty)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RFWE <= 1'b0;
            RFWA <= '0;
            RFWD <= '0;
        end else begin
            RFWE <= issue_vld;
            if (issue_vld) begin
                RFWA <= issue_req.addr;
                RFWD <= issue_req.data;
            end
        end
    end

`ifdef WB_FWD_EN
    assign FwdHit1  = RFWE && (RFWA == FwdRA1) && (RFWA != '0);
    assign FwdHit2  = RFWE && (RFWA == FwdRA2) && (RFWA != '0);
    assign FwdData1 = RFWD;
    assign FwdData2 = RFWD;
`else
    logic fwd_unused;
    assign fwd_unused = ^{FwdRA1, FwdRA2};
    assign FwdHit1  = 1'b0;
    assign FwdHit2  = 1'b0;
    assign FwdData1 = '0;
    assign FwdData2 = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Bench for rf_writeback_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_writeback_unit;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int STARVE_MAX = 8;

    logic          Clk;
    logic          Rst_n;
    logic          AValid;
    logic [AW-1:0] AAddr;
    logic [DW-1:0] AData;
    logic          BValid;
    logic          BReady;
    logic [AW-1:0] BAddr;
    logic [DW-1:0] BData;
    logic          RFWE;
    logic [AW-1:0] RFWA;
    logic [DW-1:0] RFWD;
    logic          StallReq;
    logic [AW-1:0] FwdRA1;
    logic [AW-1:0] FwdRA2;
    logic          FwdHit1;
    logic          FwdHit2;
    logic [DW-1:0] FwdData1;
    logic [DW-1:0] FwdData2;

    rf_writeback_unit #(.AW(AW), .DW(DW), .FD(FD), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .AValid(AValid), .AAddr(AAddr), .AData(AData),
        .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD), .StallReq(StallReq),
        .FwdRA1(FwdRA1), .FwdRA2(FwdRA2), .FwdHit1(FwdHit1), .FwdHit2(FwdHit2),
        .FwdData1(FwdData1), .FwdData2(FwdData2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending B writes in acceptance order, plus what the write port should show.
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    int            head_wait;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_stall;

    task automatic reset_model();
        q_addr.delete();
        q_data.delete();
        head_wait = 0;
        e_we = 1'b0; e_wa = '0; e_wd = '0; e_stall = 1'b0;
    endtask

    // Apply the current inputs for one clock and advance the model by the same edge.
    task automatic tick();
        bit a_go;
        bit can_take;
        bit have;
        bit popped;
        a_go     = AValid && (AAddr != 0);
        have     = q_addr.size() > 0;
        can_take = q_addr.size() < FD;
        popped   = !a_go && have;
        if (a_go) begin
            e_we = 1'b1; e_wa = AAddr; e_wd = AData;
        end else if (popped) begin
            e_we = 1'b1; e_wa = q_addr.pop_front(); e_wd = q_data.pop_front();
        end else begin
            e_we = 1'b0;
        end
        e_stall = !popped && have && (head_wait >= STARVE_MAX - 1);
        if (popped || !have) head_wait = 0;
        else if (head_wait < STARVE_MAX) head_wait++;
        if (BValid && can_take && BAddr != 0) begin
            q_addr.push_back(BAddr);
            q_data.push_back(BData);
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        AValid = 0; AAddr = '0; AData = '0;
        BValid = 0; BAddr = '0; BData = '0;
        FwdRA1 = '0; FwdRA2 = '0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        idle_inputs();
        reset_model();
        repeat (2) @(negedge Clk);
        n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL reset_rfwe: got %b want 0", RFWE); end
        n_cmp++; if (RFWA !== '0) begin n_err++; $display("FAIL reset_rfwa: got %h want 0", RFWA); end
        n_cmp++; if (RFWD !== '0) begin n_err++; $display("FAIL reset_rfwd: got %h want 0", RFWD); end
        n_cmp++; if (StallReq !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", StallReq); end
        Rst_n = 1'b1;
        #1;
        n_cmp++; if (BReady !== 1'b1) begin n_err++; $display("FAIL reset_bready: got %b want 1", BReady); end
    endtask

    task automatic test_a_only();
        AValid = 1; AAddr = 5'd3; AData = 32'hDEADBEEF;
        tick();
        AValid = 0;
        n_cmp++; if (RFWE !== 1'b1) begin n_err++; $display("FAIL a_only_we: got %b want 1", RFWE); end
        n_cmp++; if (RFWA !== 5'd3) begin n_err++; $display("FAIL a_only_wa: got %0d want 3", RFWA); end
        n_cmp++; if (RFWD !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_only_wd: got %h want deadbeef", RFWD); end
        tick();
        n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL a_only_idle_we: got %b want 0", RFWE); end
        n_cmp++; if (RFWA !== 5'd3 || RFWD !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL a_only_hold: got %0d/%h want 3/deadbeef", RFWA, RFWD);
        end
    endtask

    task automatic test_collision();
        AValid = 1; AAddr = 5'd5; AData = 32'h11;
        BValid = 1; BAddr = 5'd7; BData = 32'h22;
        tick();
        AValid = 0; BValid = 0;
        n_cmp++; if (RFWE !== 1'b1 || RFWA !== 5'd5 || RFWD !== 32'h11) begin
            n_err++; $display("FAIL collision_a: got %b/%0d/%h want 1/5/11", RFWE, RFWA, RFWD);
        end
        tick();
        n_cmp++; if (RFWE !== 1'b1 || RFWA !== 5'd7 || RFWD !== 32'h22) begin
            n_err++; $display("FAIL collision_b: got %b/%0d/%h want 1/7/22", RFWE, RFWA, RFWD);
        end
        tick();
        n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL collision_idle: got %b want 0", RFWE); end
    endtask

    task automatic test_full_starve();
        AValid = 1; AAddr = 5'd1; AData = 32'h0101_0101;
        for (int i = 0; i < 4; i++) begin
            BValid = 1; BAddr = 5'(10 + i); BData = 32'hB000_0000 + 32'(i);
            n_cmp++; if (BReady !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %b want 1", i, BReady); end
            tick();
        end
        BValid = 0;
        n_cmp++; if (BReady !== 1'b0) begin n_err++; $display("FAIL full_bready: got %b want 0", BReady); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (StallReq !== 1'b0) begin n_err++; $display("FAIL starve_early_%0d: got %b want 0", i, StallReq); end
        end
        tick();
        n_cmp++; if (StallReq !== 1'b1) begin n_err++; $display("FAIL starve_assert: got %b want 1", StallReq); end
        n_cmp++; if (RFWE !== 1'b1 || RFWA !== 5'd1) begin
            n_err++; $display("FAIL starve_a_wins: got %b/%0d want 1/1", RFWE, RFWA);
        end
        tick();
        n_cmp++; if (StallReq !== 1'b1) begin n_err++; $display("FAIL starve_hold: got %b want 1", StallReq); end
        AValid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (RFWE !== 1'b1 || RFWA !== 5'(10 + i) || RFWD !== 32'hB000_0000 + 32'(i)) begin
                n_err++; $display("FAIL drain_%0d: got %b/%0d/%h want 1/%0d/%h", i, RFWE, RFWA, RFWD, 10 + i, 32'hB000_0000 + 32'(i));
            end
            n_cmp++; if (StallReq !== 1'b0) begin n_err++; $display("FAIL drain_stall_%0d: got %b want 0", i, StallReq); end
        end
        n_cmp++; if (BReady !== 1'b1) begin n_err++; $display("FAIL drain_bready: got %b want 1", BReady); end
        tick();
        n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL drain_idle: got %b want 0", RFWE); end
    endtask

    task automatic test_r0();
        AValid = 1; AAddr = 5'd0; AData = 32'hFF;
        BValid = 1; BAddr = 5'd0; BData = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL r0_we_%0d: got %b want 0", i, RFWE); end
            n_cmp++; if (BReady !== 1'b1) begin n_err++; $display("FAIL r0_bready_%0d: got %b want 1", i, BReady); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL r0_after: got %b want 0", RFWE); end
    endtask

    task automatic test_reset_mid();
        AValid = 1; AAddr = 5'd2; AData = 32'h2222;
        for (int i = 0; i < 3; i++) begin
            BValid = 1; BAddr = 5'(20 + i); BData = 32'(i);
            tick();
        end
        BValid = 0;
        Rst_n = 1'b0;
        #1;
        n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL rstmid_we: got %b want 0", RFWE); end
        reset_model();
        idle_inputs();
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        n_cmp++; if (BReady !== 1'b1) begin n_err++; $display("FAIL rstmid_bready: got %b want 1", BReady); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (RFWE !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_%0d: got %b want 0", i, RFWE); end
        end
    endtask

    task automatic test_fwd();
        AValid = 1; AAddr = 5'd9; AData = 32'h1234;
        tick();
        AValid = 0;
        FwdRA1 = 5'd9; FwdRA2 = 5'd4;
        #1;
`ifdef WB_FWD_EN
        n_cmp++; if (FwdHit1 !== 1'b1 || FwdData1 !== 32'h1234) begin
            n_err++; $display("FAIL fwd_hit1: got %b/%h want 1/1234", FwdHit1, FwdData1);
        end
        n_cmp++; if (FwdHit2 !== 1'b0) begin n_err++; $display("FAIL fwd_miss2: got %b want 0", FwdHit2); end
`else
        n_cmp++; if (FwdHit1 !== 1'b0 || FwdData1 !== '0) begin
            n_err++; $display("FAIL fwd_off1: got %b/%h want 0/0", FwdHit1, FwdData1);
        end
        n_cmp++; if (FwdHit2 !== 1'b0 || FwdData2 !== '0) begin
            n_err++; $display("FAIL fwd_off2: got %b/%h want 0/0", FwdHit2, FwdData2);
        end
`endif
        @(negedge Clk);
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int a_pct;
        bit h1, h2;
        logic [DW-1:0] d1, d2;
        for (int cyc = 0; cyc < 600; cyc++) begin
            a_pct  = ((cyc / 40) % 2 == 1) ? 95 : 35;
            AValid = ($urandom_range(0, 99) < a_pct);
            AAddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            AData  = $urandom;
            BValid = ($urandom_range(0, 99) < 55);
            BAddr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            BData  = $urandom;
            FwdRA1 = ($urandom_range(0, 1) == 0) ? e_wa : 5'($urandom);
            FwdRA2 = 5'($urandom);
            #1;
            n_cmp++; if (BReady !== (q_addr.size() < FD)) begin
                n_err++; $display("FAIL rnd_bready@%0d: got %b want %b", cyc, BReady, q_addr.size() < FD);
            end
`ifdef WB_FWD_EN
            h1 = e_we && e_wa == FwdRA1 && e_wa != 0;
            h2 = e_we && e_wa == FwdRA2 && e_wa != 0;
            d1 = e_wd; d2 = e_wd;
`else
            h1 = 0; h2 = 0; d1 = '0; d2 = '0;
`endif
            n_cmp++; if (FwdHit1 !== h1 || FwdData1 !== d1 || FwdHit2 !== h2 || FwdData2 !== d2) begin
                n_err++; $display("FAIL rnd_fwd@%0d: got %b/%h %b/%h want %b/%h %b/%h", cyc, FwdHit1, FwdData1, FwdHit2, FwdData2, h1, d1, h2, d2);
            end
            tick();
            n_cmp++; if (RFWE !== e_we || RFWA !== e_wa || RFWD !== e_wd) begin
                n_err++; $display("FAIL rnd_wr@%0d: got %b/%0d/%h want %b/%0d/%h", cyc, RFWE, RFWA, RFWD, e_we, e_wa, e_wd);
            end
            n_cmp++; if (StallReq !== e_stall) begin
                n_err++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, StallReq, e_stall);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        @(negedge Clk);
        test_a_only();
        test_collision();
        test_full_starve();
        test_r0();
        test_reset_mid();
        test_fwd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
